multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 3, meaning the alu_op width (minimum 3).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning consecutive not-ready cycles before trap (0 = never).
REQ-003 The block SHALL have parameter TIMER_W, default 4, meaning the wait-counter width (2^TIMER_W > MEM_TIMEOUT).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- opcode  in  6  IR[31:26], stable from DECODE until next FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath strobes/selects
- alu_src_b, pc_source, tipols  out  2 each  ALU B mux, PC mux, access size (00 word, 01 half, 10 byte)
- alu_op  out  ALUOP_W  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- state_out  out  4  current state code
- retire  out  1  last cycle of an instruction
- illegal, mem_timeout  out  1 each  sticky trap causes

Function
REQ-006 States and codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, TRAP 12.
REQ-007 Outputs SHALL decode from state, except for the terms gated by mem_ready or zero; unlisted outputs SHALL be 0.
REQ-008 FETCH SHALL drive mem_read=1, iord=0, alu_src_b=01, alu_op=add, pc_source=00, and pc_write=ir_write=mem_ready, and SHALL go to DECODE on mem_ready, else hold.
REQ-009 DECODE SHALL drive alu_src_b=11, alu_op=add, and SHALL branch on opcode: 000000 to EXEC; 100011/100001/100000/101011/101001/101000 (lw/lh/lb/sw/sh/sb) to MEMADR; 000100 to BRANCH; 000010 to JUMP; 001000/001100/001101/001010 (addi/andi/ori/slti) to IEXEC; any other opcode to TRAP with illegal set.
REQ-010 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=add, and SHALL go to MEMRD for loads and MEMWR for stores.
REQ-011 MEMRD SHALL drive mem_read=1, iord=1, and SHALL go to MEMWB on mem_ready, else hold.
REQ-012 MEMWB SHALL drive reg_write=1, mem_to_reg=1, retire=1, then go to FETCH.
REQ-013 MEMWR SHALL drive mem_write=1, iord=1, retire=mem_ready, and SHALL go to FETCH on mem_ready, else hold.
REQ-014 tipols SHALL be valid in MEMADR, MEMRD, MEMWB and MEMWR: 00 for lw/sw, 01 for lh/sh, 10 for lb/sb; 00 elsewhere.
REQ-015 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=funct, then go to ALUWB; ALUWB SHALL drive reg_write=1, reg_dst=1, retire=1, then go to FETCH.
REQ-016 BRANCH SHALL drive alu_src_a=1, alu_op=sub, pc_source=01, pc_write=zero (beq), retire=1, then go to FETCH.
REQ-017 JUMP SHALL drive pc_source=10, pc_write=1, retire=1, then go to FETCH.
REQ-018 IEXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_op add/and/or/slt for addi/andi/ori/slti, then go to IWB; IWB SHALL drive reg_write=1, reg_dst=0, retire=1, then go to FETCH.
REQ-019 The wait counter SHALL clear on every state change and on mem_ready=1, and SHALL increment each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
REQ-020 When MEM_TIMEOUT>0 and mem_ready=0 for the MEM_TIMEOUT-th consecutive cycle in a wait state, the next state SHALL be TRAP with mem_timeout set; mem_ready=1 in that cycle takes priority.
REQ-021 TRAP SHALL hold all strobes at 0 and remain until reset; illegal and mem_timeout SHALL stay set until reset.
REQ-022 Zero-wait latencies SHALL be: lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, j 3 cycles.

Reset
REQ-023 reset_n=0 SHALL force state FETCH, clear the wait counter, illegal and mem_timeout asynchronously, and override any state, including mid-wait and TRAP.
REQ-024 During reset, outputs SHALL equal FETCH decode with pc_write=ir_write=0.

Configuration
REQ-025 With MC_BNE_EN defined, opcode 000101 SHALL go to BRANCH with pc_write=~zero; without it, 000101 SHALL be illegal.

Verification
REQ-026 lw (100011), mem_ready tied 1 -> state sequence 0,1,2,3,4,0; tipols=00; retire only in state 4.
REQ-027 sb (101000), mem_ready low 3 cycles in MEMWR -> MEMWR held 4 cycles, mem_write=1 throughout, tipols=10, retire in final cycle.
REQ-028 beq, zero=1 then zero=0 -> pc_write=1 / 0 in BRANCH; pc_source=01; 3 cycles each.
REQ-029 opcode 111111 -> TRAP after DECODE, illegal=1, strobes 0; reset_n pulse -> FETCH, illegal=0.
REQ-030 mem_ready held 0 in FETCH, MEM_TIMEOUT=15 -> TRAP entered after 15 cycles, mem_timeout=1; ready on cycle 15 -> DECODE instead.
REQ-031 bne (000101), zero=0 -> pc_write=1 with MC_BNE_EN; illegal=1 without.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-subset control FSM with memory wait timeout.
// Optional feature macro: MC_BNE_EN (accepts bne, opcode 000101).
module multicycle_control #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMER_W     = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [1:0]         tipols,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state_out,
  output logic               retire,
  output logic               illegal,
  output logic               mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);

  localparam bit TO_EN = (MEM_TIMEOUT > 0);
  localparam logic [TIMER_W-1:0] TO_LAST =
    TIMER_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               mto_q, mto_d;

  logic op_r, op_load, op_store, op_mem;
  logic op_beq, op_bne, op_j;
  logic op_addi, op_andi, op_ori, op_slti, op_imm;
  logic [1:0] size;
  logic [ALUOP_W-1:0] imm_op;
  logic wait_st, to_hit;

  assign op_r     = (opcode == 6'b000000);
  assign op_load  = (opcode == 6'b100011) ||
                    (opcode == 6'b100001) ||
                    (opcode == 6'b100000);
  assign op_store = (opcode == 6'b101011) ||
                    (opcode == 6'b101001) ||
                    (opcode == 6'b101000);
  assign op_mem   = op_load || op_store;
  assign op_beq   = (opcode == 6'b000100);
`ifdef MC_BNE_EN
  assign op_bne   = (opcode == 6'b000101);
`else
  assign op_bne   = 1'b0;
`endif
  assign op_j     = (opcode == 6'b000010);
  assign op_addi  = (opcode == 6'b001000);
  assign op_andi  = (opcode == 6'b001100);
  assign op_ori   = (opcode == 6'b001101);
  assign op_slti  = (opcode == 6'b001010);
  assign op_imm   = op_addi || op_andi || op_ori || op_slti;

  // Access size from the low opcode bits: x11 word, x01 half, x00 byte.
  assign size = (opcode[1:0] == 2'b01) ? 2'b01 :
                (opcode[1:0] == 2'b00) ? 2'b10 : 2'b00;

  assign imm_op = op_andi ? ALU_AND :
                  op_ori  ? ALU_OR  :
                  op_slti ? ALU_SLT : ALU_ADD;

  assign wait_st = (state_q == S_FETCH) ||
                   (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);

  // Fires on the last tolerated not-ready cycle of a wait state.
  assign to_hit = TO_EN && wait_st && !mem_ready &&
                  (wait_q == TO_LAST);

  // Next state, sticky trap causes and wait counter.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mto_d     = mto_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)   state_d = S_DECODE;
        else if (to_hit) state_d = S_TRAP;
      end
      S_DECODE: begin
        unique case (1'b1)
          op_r:           state_d = S_EXEC;
          op_mem:         state_d = S_MEMADR;
          op_beq, op_bne: state_d = S_BRANCH;
          op_j:           state_d = S_JUMP;
          op_imm:         state_d = S_IEXEC;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = op_store ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)   state_d = S_MEMWB;
        else if (to_hit) state_d = S_TRAP;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)   state_d = S_FETCH;
        else if (to_hit) state_d = S_TRAP;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    if (to_hit) mto_d = 1'b1;
    if ((state_d != state_q) || mem_ready)
      wait_d = '0;
    else if (wait_st)
      wait_d = wait_q + TIMER_W'(1);
    else
      wait_d = '0;
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mto_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mto_q     <= mto_d;
    end
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    tipols     = 2'b00;
    alu_op     = ALU_ADD;
    retire     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready && reset_n;
        ir_write  = mem_ready && reset_n;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        tipols    = size;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        tipols   = size;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        tipols     = size;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        tipols    = size;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FN;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = op_bne ? !zero : zero;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_op;
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out   = state_q;
  assign illegal     = illegal_q;
  assign mem_timeout = mto_q;

endmodule
